// File: rtl/shift_reg_in_pkg.sv
// Shared constants and helpers for the spike link serializer/deserializer pair.
package shift_reg_in_pkg;

  // Width of the spike vector exchanged with the core.
  localparam int SPIKE_WIDTH = 16;

  // Bit w is set when a link width of w bits is supported (1, 2, 4, 8, 16).
  localparam logic [SPIKE_WIDTH:0] LEGAL_IO_WIDTH_MASK = 17'h10116;

  // True when io_width is one of the supported link widths.
  function automatic bit is_legal_io_width(int io_width);
    if (io_width < 1 || io_width > SPIKE_WIDTH) begin
      return 1'b0;
    end
    return LEGAL_IO_WIDTH_MASK[io_width];
  endfunction

  // Index of the last beat in a frame for a given link width.
  function automatic int cnt_max(int io_width);
    return SPIKE_WIDTH / io_width - 1;
  endfunction

endpackage

// File: rtl/shift_reg_in_if.sv
// Pad-side and core-side signal bundle of the spike link deserializer.
interface shift_reg_in_if
  import shift_reg_in_pkg::*;
#(
  parameter int IO_WIDTH = 8
);

  logic                   in_valid;
  logic [IO_WIDTH-1:0]    in_spike;
  logic                   bp;
  logic                   err_clr;
  logic                   in_valid_internal;
  logic [SPIKE_WIDTH-1:0] in_spike_internal;
  logic                   out_valid;
  logic [IO_WIDTH-1:0]    out_spike;
  logic                   err;

  // Driver side: pads and control feeding the deserializer.
  modport master (
    output in_valid, in_spike, bp, err_clr,
    input  in_valid_internal, in_spike_internal, out_valid, out_spike, err
  );

  // Deserializer side.
  modport slave (
    input  in_valid, in_spike, bp, err_clr,
    output in_valid_internal, in_spike_internal, out_valid, out_spike, err
  );

endinterface

// File: rtl/shift_reg_in.sv
// Spike link input deserializer: assembles IO_WIDTH-bit beats (low slice first)
// into a 16-bit spike vector, or forwards beats unchanged in bypass mode.
module shift_reg_in
  import shift_reg_in_pkg::*;
#(
  parameter int IO_WIDTH  = 8,
  parameter int CNT_WIDTH = 1,
  parameter int CNT_MAX   = cnt_max(IO_WIDTH)
) (
  input logic          clk,
  input logic          rst_n,
  shift_reg_in_if.slave bus
);

  if (!is_legal_io_width(IO_WIDTH)) begin : g_bad_io_width
    $error("shift_reg_in: IO_WIDTH %0d is not a supported link width", IO_WIDTH);
  end

  if ((1 << CNT_WIDTH) <= CNT_MAX) begin : g_bad_cnt_width
    $error("shift_reg_in: CNT_WIDTH %0d cannot count to %0d", CNT_WIDTH, CNT_MAX);
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX);

  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SPIKE_WIDTH-1:0] asm_q, asm_d;
  logic [SPIKE_WIDTH-1:0] spike_int_q, spike_int_d;
  logic                   valid_int_q, valid_int_d;
  logic                   err_q, err_d;
  logic                   out_valid_q, out_valid_d;
  logic [IO_WIDTH-1:0]    out_spike_q, out_spike_d;

  // Assembly word including the current beat; a full-width link needs no shifting.
  logic [SPIKE_WIDTH-1:0] frame_word;

  if (IO_WIDTH == SPIKE_WIDTH) begin : g_full_width
    assign frame_word = bus.in_spike;
  end else begin : g_shift
    assign frame_word = {bus.in_spike, asm_q[SPIKE_WIDTH-1:IO_WIDTH]};
  end

  // Next-state logic: bypass forwarding, beat assembly, frame completion and gap detection.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    spike_int_d = spike_int_q;
    valid_int_d = 1'b0;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_spike_d = '0;

    if (bus.err_clr) begin
      err_d = 1'b0;
    end

    if (bus.bp) begin
      out_valid_d = bus.in_valid;
      out_spike_d = bus.in_spike;
      cnt_d       = '0;
    end else if (bus.in_valid) begin
      asm_d = frame_word;
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        spike_int_d = frame_word;
        valid_int_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = '0;
      err_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously so a partial frame never survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      spike_int_q <= '0;
      valid_int_q <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_spike_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      spike_int_q <= spike_int_d;
      valid_int_q <= valid_int_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_spike_q <= out_spike_d;
    end
  end

  assign bus.in_valid_internal = valid_int_q;
  assign bus.in_spike_internal = spike_int_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_spike         = out_spike_q;
  assign bus.err               = err_q;

endmodule

// File: tb/tb_shift_reg_in.sv
// Self-checking bench for shift_reg_in: a vector table on an 8-bit link with a
// frame scoreboard, plus hand-written sequences on a 4-bit link.
module tb_shift_reg_in;

  // One applied cycle: inputs, optional scoreboard entry, and outputs expected after the edge.
  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_spike;
    logic        bp;
    logic        err_clr;
    logic        push_en;
    logic [15:0] push_val;
    logic        exp_valid_int;
    logic [15:0] exp_spike_int;
    logic        exp_out_valid;
    logic [7:0]  exp_out_spike;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst_n;

  int vectors_applied = 0;
  int miscompares     = 0;

  vec_t        vecs[$];
  logic [15:0] frame_queue[$];

  shift_reg_in_if #(.IO_WIDTH(8)) bus8 ();
  shift_reg_in_if #(.IO_WIDTH(4)) bus4 ();

  shift_reg_in #(
    .IO_WIDTH (8),
    .CNT_WIDTH(1)
  ) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  shift_reg_in #(
    .IO_WIDTH (4),
    .CNT_WIDTH(2)
  ) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and report a miscompare.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one table vector on the 8-bit link, clock it, then check all outputs.
  task automatic applyStimulus(input vec_t v);
    rst_n         = v.rst_n;
    bus8.in_valid = v.in_valid;
    bus8.in_spike = v.in_spike;
    bus8.bp       = v.bp;
    bus8.err_clr  = v.err_clr;
    if (v.push_en) begin
      frame_queue.push_back(v.push_val);
    end
    @(posedge clk);
    #1;
    vectors_applied++;
    checkOutput("valid_int", 16'(bus8.in_valid_internal), 16'(v.exp_valid_int));
    checkOutput("spike_int", bus8.in_spike_internal, v.exp_spike_int);
    checkOutput("out_valid", 16'(bus8.out_valid), 16'(v.exp_out_valid));
    checkOutput("out_spike", 16'(bus8.out_spike), 16'(v.exp_out_spike));
    checkOutput("err", 16'(bus8.err), 16'(v.exp_err));
    @(negedge clk);
  endtask

  // Drive one beat on the 4-bit link, clock it, then check its outputs.
  task automatic step4(input logic in_valid, input logic [3:0] in_spike,
                       input logic err_clr, input logic exp_valid,
                       input logic [15:0] exp_spike, input logic exp_err);
    bus4.in_valid = in_valid;
    bus4.in_spike = in_spike;
    bus4.err_clr  = err_clr;
    @(posedge clk);
    #1;
    vectors_applied++;
    checkOutput("w4_valid_int", 16'(bus4.in_valid_internal), 16'(exp_valid));
    checkOutput("w4_spike_int", bus4.in_spike_internal, exp_spike);
    checkOutput("w4_err", 16'(bus4.err), 16'(exp_err));
    checkOutput("w4_out_valid", 16'(bus4.out_valid), 16'h0);
    checkOutput("w4_out_spike", 16'(bus4.out_spike), 16'h0);
    @(negedge clk);
  endtask

  // Scoreboard: every assembled-vector pulse on the 8-bit link must match the oldest expected frame.
  always @(negedge clk) begin
    if (bus8.in_valid_internal === 1'b1) begin
      if (frame_queue.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_pulse: got %h, expected no pulse",
                 bus8.in_spike_internal);
      end else begin
        checkOutput("sb_frame", bus8.in_spike_internal, frame_queue.pop_front());
      end
    end
  end

  // Main sequence: fill the table, run it, then the 4-bit corner cases and final scoreboard check.
  initial begin
    rst_n         = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_spike = '0;
    bus8.bp       = 1'b0;
    bus8.err_clr  = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_spike = '0;
    bus4.bp       = 1'b0;
    bus4.err_clr  = 1'b0;

    //            rst   iv    data   bp    clr   push  pval      vi    spk       ov    os     err
    // reset state
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
    // single frame 0x34, 0x12 -> 0x1234, held while idle
    vecs.push_back('{1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0});
    // back-to-back frames with valid held high
    vecs.push_back('{1'b1, 1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b1, 16'hABCD, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 16'h4321, 1'b1, 16'h4321, 1'b0, 8'h00, 1'b0});
    // frame gap sets ERR, following frame still assembles, ERR_CLR clears
    vecs.push_back('{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4321, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4321, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4321, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 16'h5678, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b0});
    // clear and new gap in the same cycle: set wins; then a clear while idle
    vecs.push_back('{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b0});
    // bypass forwarding with one cycle latency, no assembly
    vecs.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b1, 8'hA5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h3C, 1'b0});
    // partial frame dropped by bypass without ERR, then fresh assembly after bypass falls
    vecs.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b1, 8'h22, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'h00, 1'b0});
    // reset mid-frame discards the partial frame
    vecs.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'h3322, 1'b1, 16'h3322, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h3322, 1'b0, 8'h00, 1'b0});

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // 4-bit link: four beats, low nibble first, pulse one cycle after the fourth
    step4(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0);
    step4(1'b1, 4'h3, 1'b0, 1'b0, 16'h0000, 1'b0);
    step4(1'b1, 4'h2, 1'b0, 1'b0, 16'h0000, 1'b0);
    step4(1'b1, 4'h1, 1'b0, 1'b1, 16'h1234, 1'b0);
    step4(1'b0, 4'h0, 1'b0, 1'b0, 16'h1234, 1'b0);
    // 4-bit link: gap after two beats flags ERR, output held, then cleared
    step4(1'b1, 4'h5, 1'b0, 1'b0, 16'h1234, 1'b0);
    step4(1'b1, 4'h6, 1'b0, 1'b0, 16'h1234, 1'b0);
    step4(1'b0, 4'h0, 1'b0, 1'b0, 16'h1234, 1'b1);
    step4(1'b0, 4'h0, 1'b0, 1'b0, 16'h1234, 1'b1);
    step4(1'b0, 4'h0, 1'b1, 1'b0, 16'h1234, 1'b0);

    checkOutput("sb_pending_frames", 16'(frame_queue.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
